// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder and the datapath.
package slc3_mem_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        DONE
    } mem_state_t;

    localparam word_t DEFAULT_IO_ADDR = 16'hFFFF;

    localparam int unsigned CNT_W = 3;
    typedef logic [CNT_W-1:0] cnt_t;

    // RD_WAIT spends one cycle per count value down to and including zero.
    function automatic cnt_t wait_preload(input int unsigned rd_lat);
        return cnt_t'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 3-bit down-counter; stops at zero and flags it.
module mem_wait_counter
    import slc3_mem_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [2:0] D_In,
    output logic       Zero
);

    cnt_t count_q;
    cnt_t count_d;

    always_comb begin
        count_d = count_q;
        if (Load) begin
            count_d = D_In;
        end else if (count_q != '0) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Zero = (count_q == '0);

endmodule

// File: rtl/slc3_mem_responder.sv
// Serves SLC-3 MAR/MDR load/store requests from synchronous SRAM or the switch/hex I/O word,
// acknowledging each with a 4-phase R handshake.
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int unsigned RD_LAT  = 2,
    parameter word_t       IO_ADDR = DEFAULT_IO_ADDR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] MDR_In,
    output logic        R,
    input  logic [15:0] SW,
    output logic [15:0] HEX,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_re,
    output logic        sram_we,
    input  logic [15:0] sram_rdata
);

    localparam cnt_t WAIT_PRELOAD = wait_preload(RD_LAT);

    mem_state_t state_q, state_d;
    word_t      addr_d, wdata_d, mdr_in_d, hex_d;
    logic       is_io;
    logic       cnt_load;
    logic       cnt_zero;

    assign is_io = (MAR == IO_ADDR);

    always_comb begin
        state_d  = state_q;
        addr_d   = sram_addr;
        wdata_d  = sram_wdata;
        mdr_in_d = MDR_In;
        hex_d    = HEX;
        cnt_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A write wins when both requests are raised together.
                if (MEM_WE) begin
                    addr_d  = MAR;
                    wdata_d = MDR;
                    if (is_io) begin
                        hex_d   = MDR;
                        state_d = DONE;
                    end else begin
                        state_d = WR_ISSUE;
                    end
                end else if (MEM_OE) begin
                    addr_d = MAR;
                    if (is_io) begin
                        mdr_in_d = SW;
                        state_d  = DONE;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                cnt_load = 1'b1;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_zero) begin
                    mdr_in_d = sram_rdata;
                    state_d  = DONE;
                end
            end
            WR_ISSUE: begin
                state_d = DONE;
            end
            DONE: begin
                // Hold the acknowledge until the requester lets go.
                if (!(MEM_OE || MEM_WE)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            sram_addr  <= '0;
            sram_wdata <= '0;
            MDR_In     <= '0;
            HEX        <= '0;
        end else begin
            state_q    <= state_d;
            sram_addr  <= addr_d;
            sram_wdata <= wdata_d;
            MDR_In     <= mdr_in_d;
            HEX        <= hex_d;
        end
    end

    assign sram_re = (state_q == RD_ISSUE);
    assign sram_we = (state_q == WR_ISSUE);
    assign R       = (state_q == DONE);

    mem_wait_counter u_wait_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (cnt_load),
        .D_In  (WAIT_PRELOAD),
        .Zero  (cnt_zero)
    );

    strobe_exclusive: assert property (@(posedge Clk) !(sram_re && sram_we));

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed, table-driven bench for slc3_mem_responder with a fixed-latency SRAM model.
module tb_slc3_mem_responder;

    localparam int unsigned RD_LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MEM_OE, MEM_WE;
    logic [15:0] MAR, MDR, SW;
    logic [15:0] MDR_In, HEX;
    logic        R;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_re, sram_we;

    always #5 Clk = ~Clk;

    slc3_mem_responder #(
        .RD_LAT  (RD_LAT),
        .IO_ADDR (16'hFFFF)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MEM_OE     (MEM_OE),
        .MEM_WE     (MEM_WE),
        .MAR        (MAR),
        .MDR        (MDR),
        .MDR_In     (MDR_In),
        .R          (R),
        .SW         (SW),
        .HEX        (HEX),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_rdata (sram_rdata)
    );

    // SRAM model: data is valid only RD_LAT cycles after the sram_re cycle, junk otherwise.
    logic [15:0] model_rdata;
    logic [15:0] rd_pipe [RD_LAT];

    always @(posedge Clk) begin
        rd_pipe[0] <= sram_re ? model_rdata : 16'hDEAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[RD_LAT-1];

    typedef struct {
        logic        we;
        logic        oe;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] rdata;
        logic [15:0] exp_mdr;
        logic [15:0] exp_hex;
        int          exp_r_cycle;
        int          exp_re;
        int          exp_we;
        int          hold;
    } vec_t;

    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic we, input logic oe, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] sw,
                                input logic [15:0] rdata, input logic [15:0] exp_mdr,
                                input logic [15:0] exp_hex, input int exp_r_cycle,
                                input int exp_re, input int exp_we, input int hold);
        vec_t v;
        v.we = we; v.oe = oe; v.addr = addr; v.wdata = wdata; v.sw = sw; v.rdata = rdata;
        v.exp_mdr = exp_mdr; v.exp_hex = exp_hex; v.exp_r_cycle = exp_r_cycle;
        v.exp_re = exp_re; v.exp_we = exp_we; v.hold = hold;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Inputs for cycle 0 are already applied; watch the transaction through release.
    task automatic observe(input vec_t v, input int idx);
        int          r_cyc, re_n, we_n, re_cyc, we_cyc, hold_err;
        logic [15:0] re_addr, we_addr, we_data;
        r_cyc = -1; re_n = 0; we_n = 0; re_cyc = -1; we_cyc = -1; hold_err = 0;
        re_addr = '0; we_addr = '0; we_data = '0;

        @(negedge Clk);
        check("cycle0_quiet", idx, {29'd0, R, sram_re, sram_we}, 32'd0);

        for (int c = 1; c <= 30 && r_cyc < 0; c++) begin
            @(negedge Clk);
            if (sram_re) begin re_n++; re_cyc = c; re_addr = sram_addr; end
            if (sram_we) begin we_n++; we_cyc = c; we_addr = sram_addr; we_data = sram_wdata; end
            if (R) r_cyc = c;
            if (c == 1) begin
                // Accepted request: later changes must be ignored.
                MAR = ~v.addr; MDR = ~v.wdata; SW = ~v.sw;
            end
        end

        check("r_cycle", idx, r_cyc, v.exp_r_cycle);
        check("re_count", idx, re_n, v.exp_re);
        check("we_count", idx, we_n, v.exp_we);
        if (v.exp_re > 0) begin
            check("re_cycle", idx, re_cyc, 1);
            check("re_addr", idx, {16'd0, re_addr}, {16'd0, v.addr});
        end
        if (v.exp_we > 0) begin
            check("we_cycle", idx, we_cyc, 1);
            check("we_addr", idx, {16'd0, we_addr}, {16'd0, v.addr});
            check("we_data", idx, {16'd0, we_data}, {16'd0, v.wdata});
        end
        check("mdr_in", idx, {16'd0, MDR_In}, {16'd0, v.exp_mdr});
        check("hex", idx, {16'd0, HEX}, {16'd0, v.exp_hex});

        for (int h = 0; h < v.hold; h++) begin
            @(negedge Clk);
            if (sram_re || sram_we || !R) hold_err++;
        end
        check("hold_quiet", idx, hold_err, 0);

        @(posedge Clk);
        #1;
        MEM_OE = 1'b0;
        MEM_WE = 1'b0;
        @(negedge Clk);
        check("r_after_drop", idx, {31'd0, R}, 32'd1);
        @(negedge Clk);
        check("r_fall", idx, {29'd0, R, sram_re, sram_we}, 32'd0);
        check("mdr_hex_kept", idx, {MDR_In, HEX}, {v.exp_mdr, v.exp_hex});
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge Clk);
        #1;
        MEM_WE = v.we; MEM_OE = v.oe; MAR = v.addr; MDR = v.wdata; SW = v.sw;
        model_rdata = v.rdata;
        observe(v, idx);
    endtask

    initial begin
        //             we    oe    addr      wdata     sw        rdata     mdr       hex     rc re we hold
        vecs[0] = mk(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h0000, 4, 1, 0, 0);
        vecs[1] = mk(1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 16'h0000, 4, 1, 0, 0);
        vecs[2] = mk(1'b1, 1'b0, 16'h0100, 16'hCAFE, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 2, 0, 1, 1);
        vecs[3] = mk(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 16'h0000, 16'h1234, 16'h00A5, 1, 0, 0, 0);
        vecs[4] = mk(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h00A5, 1, 0, 0, 2);
        vecs[5] = mk(1'b1, 1'b1, 16'h0200, 16'h5A5A, 16'h0000, 16'h7777, 16'hBEEF, 16'h00A5, 2, 0, 1, 5);
        vecs[6] = mk(1'b0, 1'b1, 16'h7FFE, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 16'h00A5, 4, 1, 0, 0);
        vecs[7] = mk(1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'hFFFF, 16'h0000, 16'h8001, 16'h1234, 1, 0, 0, 1);
        vecs[8] = mk(1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 4, 1, 0, 0);
        vecs[9] = mk(1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 2, 0, 1, 3);

        // Reset held with a read request pending.
        Reset = 1'b1; MEM_OE = 1'b1; MEM_WE = 1'b0;
        MAR = vecs[0].addr; MDR = '0; SW = '0; model_rdata = vecs[0].rdata;
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            check("reset_ctl", k, {29'd0, R, sram_re, sram_we}, 32'd0);
            check("reset_data", k, {MDR_In, HEX}, 32'd0);
            check("reset_sram", k, {sram_addr, sram_wdata}, 32'd0);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        observe(vecs[0], 0);

        for (int i = 1; i < 10; i++) apply(vecs[i], i);

        // Reset during RD_WAIT aborts the read; late SRAM data must not land.
        @(posedge Clk);
        #1;
        MEM_OE = 1'b1; MEM_WE = 1'b0; MAR = 16'h0300; model_rdata = 16'h4444;
        @(negedge Clk);
        check("abort_c0", 0, {31'd0, R}, 32'd0);
        @(negedge Clk);
        check("abort_re", 0, {31'd0, sram_re}, 32'd1);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        MEM_OE = 1'b0;
        @(negedge Clk);
        check("abort_wait", 0, {30'd0, sram_re, R}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("abort_ctl", 0, {29'd0, R, sram_re, sram_we}, 32'd0);
        check("abort_data", 0, {MDR_In, HEX}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            check("abort_after", k, {R, sram_re, sram_we, 13'd0, MDR_In}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
